// File: rtl/sram_axi_bridge.sv
// Bridges the core's instruction and data SRAM-like ports onto a single-beat
// AXI master, one transaction in flight, with stall feedback to the core.
module sram_axi_bridge (
  input  logic        clk,
  input  logic        rst,

  input  logic        inst_sram_en,
  input  logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_rdata,
  output logic        fetch_stall,

  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic        memory_stall,

  input  logic        longest_stall,

  output logic [31:0] araddr,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic        rvalid,
  output logic        rready,

  output logic [31:0] awaddr,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wvalid,
  input  logic        wready,
  input  logic        bvalid,
  output logic        bready
);

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_DATA,
    WR,
    WR_RESP
  } state_t;

  state_t      state, state_nxt;
  logic        src_data;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic        aw_done, w_done;
  logic        inst_done, data_done;
  logic [31:0] inst_rdata_q, data_rdata_q;

  logic        issue_wr, issue_rd_data, issue_rd_inst, issue_any;
  logic        aw_hs, w_hs, r_hs, b_hs;

  assign fetch_stall  = inst_sram_en & ~inst_done;
  assign memory_stall = data_sram_en & ~data_done;

  assign araddr          = addr_q;
  assign awaddr          = addr_q;
  assign wdata           = wdata_q;
  assign wstrb           = wstrb_q;
  assign inst_sram_rdata = inst_rdata_q;
  assign data_sram_rdata = data_rdata_q;

  assign issue_any = issue_wr | issue_rd_data | issue_rd_inst;
  assign aw_hs     = awvalid & awready;
  assign w_hs      = wvalid & wready;
  assign r_hs      = rready & rvalid;
  assign b_hs      = bready & bvalid;

  always_comb begin
    state_nxt     = state;
    issue_wr      = 1'b0;
    issue_rd_data = 1'b0;
    issue_rd_inst = 1'b0;
    arvalid       = 1'b0;
    rready        = 1'b0;
    awvalid       = 1'b0;
    wvalid        = 1'b0;
    bready        = 1'b0;
    case (state)
      IDLE: begin
        // Data port wins so a pending load/store never waits behind a fetch.
        if (memory_stall && (data_sram_wen != 4'b0000)) begin
          issue_wr  = 1'b1;
          state_nxt = WR;
        end else if (memory_stall) begin
          issue_rd_data = 1'b1;
          state_nxt     = RD_ADDR;
        end else if (fetch_stall) begin
          issue_rd_inst = 1'b1;
          state_nxt     = RD_ADDR;
        end
      end
      RD_ADDR: begin
        arvalid = 1'b1;
        if (arready) state_nxt = RD_DATA;
      end
      RD_DATA: begin
        rready = 1'b1;
        if (rvalid) state_nxt = IDLE;
      end
      WR: begin
        awvalid = ~aw_done;
        wvalid  = ~w_done;
        if ((aw_done | awready) && (w_done | wready)) state_nxt = WR_RESP;
      end
      WR_RESP: begin
        bready = 1'b1;
        if (bvalid) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      src_data     <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      aw_done      <= 1'b0;
      w_done       <= 1'b0;
      inst_done    <= 1'b0;
      data_done    <= 1'b0;
      inst_rdata_q <= '0;
      data_rdata_q <= '0;
    end else begin
      state <= state_nxt;

      if (issue_any) begin
        addr_q   <= issue_rd_inst ? inst_sram_addr : data_sram_addr;
        src_data <= ~issue_rd_inst;
        aw_done  <= 1'b0;
        w_done   <= 1'b0;
      end
      if (issue_wr) begin
        wdata_q <= data_sram_wdata;
        wstrb_q <= data_sram_wen;
      end

      if (aw_hs) aw_done <= 1'b1;
      if (w_hs)  w_done  <= 1'b1;

      // Clear first so a completion on the same edge takes priority.
      if (!longest_stall) begin
        inst_done <= 1'b0;
        data_done <= 1'b0;
      end
      if (r_hs) begin
        if (src_data) begin
          data_rdata_q <= rdata;
          data_done    <= 1'b1;
        end else begin
          inst_rdata_q <= rdata;
          inst_done    <= 1'b1;
        end
      end
      if (b_hs) data_done <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sram_axi_bridge.sv
// Self-checking bench for sram_axi_bridge: table-driven single transactions
// through a delay-configurable AXI slave, plus multi-cycle corner sequences.
module tb_sram_axi_bridge;

  logic        clk;
  logic        rst;
  logic        inst_sram_en;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_rdata;
  logic        fetch_stall;
  logic        data_sram_en;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;
  logic        memory_stall;
  logic        longest_stall;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic        rvalid;
  logic        rready;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic        bvalid;
  logic        bready;

  sram_axi_bridge dut (
    .clk             (clk),
    .rst             (rst),
    .inst_sram_en    (inst_sram_en),
    .inst_sram_addr  (inst_sram_addr),
    .inst_sram_rdata (inst_sram_rdata),
    .fetch_stall     (fetch_stall),
    .data_sram_en    (data_sram_en),
    .data_sram_wen   (data_sram_wen),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata),
    .data_sram_rdata (data_sram_rdata),
    .memory_stall    (memory_stall),
    .longest_stall   (longest_stall),
    .araddr          (araddr),
    .arvalid         (arvalid),
    .arready         (arready),
    .rdata           (rdata),
    .rvalid          (rvalid),
    .rready          (rready),
    .awaddr          (awaddr),
    .awvalid         (awvalid),
    .awready         (awready),
    .wdata           (wdata),
    .wstrb           (wstrb),
    .wvalid          (wvalid),
    .wready          (wready),
    .bvalid          (bvalid),
    .bready          (bready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] rdata;
  } axi_exp_t;

  typedef struct {
    logic        is_inst;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] slv_rdata;
    int unsigned d_addr;
    int unsigned d_w;
    int unsigned d_resp;
    logic [31:0] exp_rdata;
    int unsigned exp_lat;
  } vec_t;

  axi_exp_t    axi_q[$];
  vec_t        vecs[7];
  int unsigned checks = 0;
  int unsigned errors = 0;

  int unsigned sl_d_addr = 0;
  int unsigned sl_d_w    = 0;
  int unsigned sl_d_resp = 0;
  int unsigned ar_cyc = 0, aw_cyc = 0, w_cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got handshake with no pending transaction expected none (t=%0t)", name, $time);
  endtask

  // AXI slave: decides ready/valid just after each negedge for the next posedge.
  initial begin : slave
    int unsigned ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt;
    bit aw_seen, w_seen;
    arready = 1'b0; rvalid = 1'b0; rdata = '0;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
    ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
    aw_seen = 1'b0; w_seen = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        arready = 1'b0; rvalid = 1'b0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
        ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
        aw_seen = 1'b0; w_seen = 1'b0;
      end else begin
        if (arvalid) begin
          ar_cyc++;
          if (axi_q.size() == 0 || axi_q[0].wr) unexpected("ar_unexpected");
          else chk("araddr", araddr, axi_q[0].addr);
          arready = (ar_cnt >= sl_d_addr);
          ar_cnt++;
        end else begin
          arready = 1'b0;
          ar_cnt  = 0;
        end

        if (rready) begin
          rvalid = (r_cnt >= sl_d_resp);
          r_cnt++;
          rdata = (axi_q.size() != 0) ? axi_q[0].rdata : '0;
          if (rvalid) begin
            if (axi_q.size() == 0) unexpected("r_unexpected");
            else void'(axi_q.pop_front());
          end
        end else begin
          rvalid = 1'b0;
          r_cnt  = 0;
        end

        if (awvalid) begin
          aw_cyc++;
          if (axi_q.size() == 0 || !axi_q[0].wr) unexpected("aw_unexpected");
          else chk("awaddr", awaddr, axi_q[0].addr);
          awready = (aw_cnt >= sl_d_addr);
          aw_cnt++;
          if (awready) aw_seen = 1'b1;
        end else begin
          awready = 1'b0;
          aw_cnt  = 0;
        end

        if (wvalid) begin
          w_cyc++;
          if (axi_q.size() == 0 || !axi_q[0].wr) unexpected("w_unexpected");
          else begin
            chk("wdata", wdata, axi_q[0].wdata);
            chk("wstrb", {28'h0, wstrb}, {28'h0, axi_q[0].strb});
          end
          wready = (w_cnt >= sl_d_w);
          w_cnt++;
          if (wready) w_seen = 1'b1;
        end else begin
          wready = 1'b0;
          w_cnt  = 0;
        end

        if (aw_seen && w_seen) begin
          if (axi_q.size() != 0) void'(axi_q.pop_front());
          aw_seen = 1'b0;
          w_seen  = 1'b0;
        end

        if (bready) begin
          bvalid = (b_cnt >= sl_d_resp);
          b_cnt++;
        end else begin
          bvalid = 1'b0;
          b_cnt  = 0;
        end
      end
    end
  end

  task automatic release_pipe();
    longest_stall = 1'b0;
    inst_sram_en  = 1'b0;
    data_sram_en  = 1'b0;
    @(negedge clk);
    longest_stall = 1'b1;
  endtask

  task automatic run_op(input vec_t v);
    int unsigned lat;
    bit          done;
    axi_exp_t    e;
    sl_d_addr = v.d_addr;
    sl_d_w    = v.d_w;
    sl_d_resp = v.d_resp;
    ar_cyc = 0; aw_cyc = 0; w_cyc = 0;
    e.wr    = !v.is_inst && (v.wen != 4'b0000);
    e.addr  = v.addr;
    e.wdata = v.wdata;
    e.strb  = v.wen;
    e.rdata = v.slv_rdata;
    axi_q.push_back(e);
    longest_stall = 1'b1;
    if (v.is_inst) begin
      inst_sram_en   = 1'b1;
      inst_sram_addr = v.addr;
    end else begin
      data_sram_en    = 1'b1;
      data_sram_wen   = v.wen;
      data_sram_addr  = v.addr;
      data_sram_wdata = v.wdata;
    end
    lat  = 0;
    done = 1'b0;
    while (!done && lat < 60) begin
      @(negedge clk);
      lat++;
      done = v.is_inst ? !fetch_stall : !memory_stall;
    end
    chk("latency", lat, v.exp_lat);
    if (v.is_inst) begin
      chk("inst_rdata", inst_sram_rdata, v.exp_rdata);
      chk("ar_cycles", ar_cyc, v.d_addr + 1);
    end else if (v.wen == 4'b0000) begin
      chk("data_rdata", data_sram_rdata, v.exp_rdata);
      chk("ar_cycles", ar_cyc, v.d_addr + 1);
    end else begin
      chk("aw_cycles", aw_cyc, v.d_addr + 1);
      chk("w_cycles", w_cyc, v.d_w + 1);
    end
    chk("axi_pending", 32'(axi_q.size()), 32'd0);
    release_pipe();
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : test
    int unsigned lat, mem_lat, fetch_lat;
    axi_exp_t    e;
    logic [31:0] held;

    vecs[0] = '{1'b1, 4'h0, 32'h1FC0_0000, 32'h0,         32'h3C1D_0001, 0, 0, 0, 32'h3C1D_0001, 3};
    vecs[1] = '{1'b0, 4'h0, 32'h0000_0100, 32'h0,         32'hCAFE_F00D, 1, 0, 2, 32'hCAFE_F00D, 6};
    vecs[2] = '{1'b0, 4'h3, 32'h0000_1004, 32'hAABB_CCDD, 32'h0,         0, 2, 0, 32'h0,         5};
    vecs[3] = '{1'b0, 4'hF, 32'h0000_2000, 32'hDEAD_BEEF, 32'h0,         3, 0, 1, 32'h0,         7};
    vecs[4] = '{1'b0, 4'h8, 32'h0000_3FFC, 32'h0102_0304, 32'h0,         0, 0, 0, 32'h0,         3};
    vecs[5] = '{1'b1, 4'h0, 32'hBFC0_0380, 32'h0,         32'hFFFF_FFFF, 2, 0, 3, 32'hFFFF_FFFF, 8};
    vecs[6] = '{1'b0, 4'h0, 32'h0000_0000, 32'h0,         32'h8000_0000, 0, 0, 0, 32'h8000_0000, 3};

    rst = 1'b1;
    longest_stall = 1'b1;
    inst_sram_en = 1'b0; inst_sram_addr = '0;
    data_sram_en = 1'b0; data_sram_wen = '0; data_sram_addr = '0; data_sram_wdata = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_valids", {27'h0, arvalid, awvalid, wvalid, rready, bready}, 32'h0);
    chk("rst_inst_rdata", inst_sram_rdata, 32'h0);
    chk("rst_data_rdata", data_sram_rdata, 32'h0);
    chk("rst_araddr", araddr, 32'h0);
    chk("rst_wdata", wdata, 32'h0);
    chk("rst_wstrb", {28'h0, wstrb}, 32'h0);
    chk("rst_stalls_idle", {30'h0, fetch_stall, memory_stall}, 32'h0);
    inst_sram_en = 1'b1;
    data_sram_en = 1'b1;
    @(negedge clk);
    chk("rst_stalls_req", {30'h0, fetch_stall, memory_stall}, 32'h3);
    chk("rst_no_issue", {31'h0, arvalid}, 32'h0);
    inst_sram_en = 1'b0;
    data_sram_en = 1'b0;
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 7; i++) run_op(vecs[i]);

    // Simultaneous load and fetch: data is served first
    sl_d_addr = 0; sl_d_w = 0; sl_d_resp = 0;
    e = '{1'b0, 32'h0000_0040, 32'h0, 4'h0, 32'h1234_5678};
    axi_q.push_back(e);
    e = '{1'b0, 32'h1FC0_0004, 32'h0, 4'h0, 32'h2408_0005};
    axi_q.push_back(e);
    data_sram_en = 1'b1; data_sram_wen = 4'h0; data_sram_addr = 32'h0000_0040;
    inst_sram_en = 1'b1; inst_sram_addr = 32'h1FC0_0004;
    lat = 0; mem_lat = 0; fetch_lat = 0;
    while (fetch_lat == 0 && lat < 60) begin
      @(negedge clk);
      lat++;
      if (mem_lat == 0 && !memory_stall) mem_lat = lat;
      if (fetch_lat == 0 && !fetch_stall) fetch_lat = lat;
    end
    chk("both_mem_lat", mem_lat, 32'd3);
    chk("both_fetch_lat", fetch_lat, 32'd6);
    chk("both_data_rdata", data_sram_rdata, 32'h1234_5678);
    chk("both_inst_rdata", inst_sram_rdata, 32'h2408_0005);

    // Pipeline held: no re-issue, results hold
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("hold_arvalid", {31'h0, arvalid}, 32'h0);
      chk("hold_stalls", {30'h0, fetch_stall, memory_stall}, 32'h0);
      chk("hold_inst_rdata", inst_sram_rdata, 32'h2408_0005);
      chk("hold_data_rdata", data_sram_rdata, 32'h1234_5678);
    end
    e = '{1'b0, 32'h1FC0_0008, 32'h0, 4'h0, 32'h8FA4_0010};
    axi_q.push_back(e);
    inst_sram_addr = 32'h1FC0_0008;
    data_sram_en   = 1'b0;
    longest_stall  = 1'b0;
    @(negedge clk);
    longest_stall = 1'b1;
    chk("advance_fetch_stall", {31'h0, fetch_stall}, 32'h1);
    chk("advance_rdata_held", inst_sram_rdata, 32'h2408_0005);
    lat = 0;
    while (fetch_stall && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    chk("advance_lat", lat, 32'd3);
    chk("advance_inst_rdata", inst_sram_rdata, 32'h8FA4_0010);
    release_pipe();

    // Reset in the middle of a read
    sl_d_addr = 0; sl_d_resp = 3;
    e = '{1'b0, 32'h1FC0_0010, 32'h0, 4'h0, 32'h27BD_FFE8};
    axi_q.push_back(e);
    inst_sram_en = 1'b1; inst_sram_addr = 32'h1FC0_0010;
    lat = 0;
    while (!rready && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("midrd_reached_rdata", {31'h0, rready}, 32'h1);
    held = data_sram_rdata;
    chk("midrd_data_nonzero_before", {31'h0, held != 32'h0}, 32'h1);
    rst = 1'b1;
    @(negedge clk);
    chk("midrd_valids", {27'h0, arvalid, awvalid, wvalid, rready, bready}, 32'h0);
    chk("midrd_inst_rdata", inst_sram_rdata, 32'h0);
    chk("midrd_data_rdata", data_sram_rdata, 32'h0);
    chk("midrd_fetch_stall", {31'h0, fetch_stall}, 32'h1);
    sl_d_resp = 0;
    @(negedge clk);
    rst = 1'b0;
    lat = 0;
    while (fetch_stall && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    chk("midrd_reissue_lat", lat, 32'd3);
    chk("midrd_reissue_rdata", inst_sram_rdata, 32'h27BD_FFE8);
    chk("midrd_axi_pending", 32'(axi_q.size()), 32'd0);
    release_pipe();
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
